// File: rtl/thread_pc_sched.sv
// Round-robin multithreaded fetch scheduler: one PC per thread, one fetch per cycle.
// Define SCHED_PERF_CNT_EN to add the 32-bit issue_count performance counter output.
module thread_pc_sched #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_W       = 2,
  parameter int unsigned PC_W        = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   start_valid,
  input  logic [TID_W-1:0]       start_tid,
  input  logic [PC_W-1:0]        start_addr,
  input  logic                   halt_valid,
  input  logic [TID_W-1:0]       halt_tid,
  input  logic                   redirect_valid,
  input  logic [TID_W-1:0]       redirect_tid,
  input  logic [PC_W-1:0]        redirect_addr,
  output logic                   fetch_valid,
  output logic [TID_W-1:0]       fetch_tid,
  output logic [PC_W-1:0]        fetch_pc,
  output logic [NUM_THREADS-1:0] thread_active
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]            issue_count
`endif
);

  localparam int unsigned CNT_W = 32;

  logic [PC_W-1:0]        pc_q   [NUM_THREADS];
  logic [PC_W-1:0]        pc_d   [NUM_THREADS];
  logic [PC_W-1:0]        eff_pc [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_q, active_d;
  logic [TID_W-1:0]       last_q, last_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [TID_W-1:0]       fetch_tid_q, fetch_tid_d;
  logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic                   grant_found;
  logic [TID_W-1:0]       grant_tid;
  logic [TID_W-1:0]       scan_tid;

  // Apply this cycle's start/halt/redirect; priority start > halt (active thread) > redirect.
  always_comb begin
    active_d = active_q;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      eff_pc[t] = pc_q[t];
      if (start_valid && start_tid == TID_W'(t)) begin
        active_d[t] = 1'b1;
        eff_pc[t]   = start_addr;
      end else if (halt_valid && halt_tid == TID_W'(t) && active_q[t]) begin
        active_d[t] = 1'b0;
      end else if (redirect_valid && redirect_tid == TID_W'(t)) begin
        eff_pc[t] = redirect_addr;
      end
    end
  end

  // First eligible thread after last_q; the index wraps naturally at TID_W bits.
  always_comb begin
    grant_found = 1'b0;
    grant_tid   = '0;
    scan_tid    = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      scan_tid = last_q + TID_W'(i);
      if (!grant_found && active_d[scan_tid]) begin
        grant_found = 1'b1;
        grant_tid   = scan_tid;
      end
    end
  end

  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      pc_d[t] = eff_pc[t];
    end
    last_d        = last_q;
    fetch_valid_d = fetch_valid_q;
    fetch_tid_d   = fetch_tid_q;
    fetch_pc_d    = fetch_pc_q;
    if (!stall) begin
      if (grant_found) begin
        fetch_valid_d   = 1'b1;
        fetch_tid_d     = grant_tid;
        fetch_pc_d      = eff_pc[grant_tid];
        pc_d[grant_tid] = eff_pc[grant_tid] + PC_W'(1);
        last_d          = grant_tid;
      end else begin
        fetch_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= '0;
      end
      active_q      <= '0;
      last_q        <= TID_W'(NUM_THREADS - 1);
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= '0;
      fetch_pc_q    <= '0;
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= pc_d[t];
      end
      active_q      <= active_d;
      last_q        <= last_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_tid_q   <= fetch_tid_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign fetch_valid   = fetch_valid_q;
  assign fetch_tid     = fetch_tid_q;
  assign fetch_pc      = fetch_pc_q;
  assign thread_active = active_q;

`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] issue_count_q, issue_count_d;

  // Counts new grants only; a stalled hold does not count again.
  always_comb begin
    issue_count_d = issue_count_q;
    if (!stall && grant_found) begin
      issue_count_d = issue_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count_q <= '0;
    end else begin
      issue_count_q <= issue_count_d;
    end
  end

  assign issue_count = issue_count_q;
`endif

endmodule

// File: tb/tb_thread_pc_sched.sv
// Bench for thread_pc_sched: directed scenarios with literal expectations plus
// randomized events checked every cycle against a behavioural thread model.
module tb_thread_pc_sched;
  localparam int NT = 4;
  localparam int TW = 2;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          start_valid;
  logic [TW-1:0] start_tid;
  logic [PW-1:0] start_addr;
  logic          halt_valid;
  logic [TW-1:0] halt_tid;
  logic          redirect_valid;
  logic [TW-1:0] redirect_tid;
  logic [PW-1:0] redirect_addr;
  logic          fetch_valid;
  logic [TW-1:0] fetch_tid;
  logic [PW-1:0] fetch_pc;
  logic [NT-1:0] thread_active;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]   issue_count;
`endif

  thread_pc_sched #(.NUM_THREADS(NT), .TID_W(TW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .start_valid(start_valid), .start_tid(start_tid), .start_addr(start_addr),
    .halt_valid(halt_valid), .halt_tid(halt_tid),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_addr(redirect_addr),
    .fetch_valid(fetch_valid), .fetch_tid(fetch_tid), .fetch_pc(fetch_pc),
    .thread_active(thread_active)
`ifdef SCHED_PERF_CNT_EN
    , .issue_count(issue_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: per-thread PC and active flag, rotation pointer, issued fetch.
  int          m_pc  [NT];
  bit          m_act [NT];
  int          m_last;
  bit          m_fv;
  int          m_ftid;
  int          m_fpc;
  int unsigned m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_pc[t]  = 0;
      m_act[t] = 0;
    end
    m_last = NT - 1;
    m_fv   = 0;
    m_ftid = 0;
    m_fpc  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    bit nact [NT];
    int npc  [NT];
    int g;
    for (int t = 0; t < NT; t++) begin
      nact[t] = m_act[t];
      npc[t]  = m_pc[t];
      if (start_valid && int'(start_tid) == t) begin
        nact[t] = 1;
        npc[t]  = int'(start_addr);
      end else if (halt_valid && int'(halt_tid) == t && m_act[t]) begin
        nact[t] = 0;
      end else if (redirect_valid && int'(redirect_tid) == t) begin
        npc[t] = int'(redirect_addr);
      end
    end
    if (!stall) begin
      g = -1;
      for (int k = 1; k <= NT; k++) begin
        if (g < 0 && nact[(m_last + k) % NT]) g = (m_last + k) % NT;
      end
      if (g >= 0) begin
        m_fv    = 1;
        m_ftid  = g;
        m_fpc   = npc[g];
        npc[g]  = (npc[g] + 1) % (1 << PW);
        m_last  = g;
        m_cnt++;
      end else begin
        m_fv = 0;
      end
    end
    for (int t = 0; t < NT; t++) begin
      m_pc[t]  = npc[t];
      m_act[t] = nact[t];
    end
  endtask

  task automatic compare_all();
    int av = 0;
    for (int t = 0; t < NT; t++) if (m_act[t]) av = av | (1 << t);
    chk("fetch_valid", int'(fetch_valid), int'(m_fv));
    chk("fetch_tid", int'(fetch_tid), m_ftid);
    chk("fetch_pc", int'(fetch_pc), m_fpc);
    chk("thread_active", int'(thread_active), av);
`ifdef SCHED_PERF_CNT_EN
    chk("issue_count", int'(issue_count), int'(m_cnt));
`endif
  endtask

  task automatic lit(input string name, input int tid, input int pc);
    chk({name, " valid"}, int'(fetch_valid), 1);
    chk({name, " tid"}, int'(fetch_tid), tid);
    chk({name, " pc"}, int'(fetch_pc), pc);
  endtask

  task automatic clr();
    stall = 0; start_valid = 0; start_tid = '0; start_addr = '0;
    halt_valid = 0; halt_tid = '0;
    redirect_valid = 0; redirect_tid = '0; redirect_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
    clr();
  endtask

  task automatic do_start(input int tid, input int addr);
    start_valid = 1; start_tid = TW'(tid); start_addr = PW'(addr);
  endtask

  task automatic do_redirect(input int tid, input int addr);
    redirect_valid = 1; redirect_tid = TW'(tid); redirect_addr = PW'(addr);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic apply_reset();
    #2 rst = 1;
    model_reset();
    #1;
    compare_all();
    rst = 0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1;
    model_reset();
    #1;
    chk("reset fetch_valid", int'(fetch_valid), 0);
    chk("reset fetch_tid", int'(fetch_tid), 0);
    chk("reset fetch_pc", int'(fetch_pc), 0);
    chk("reset active", int'(thread_active), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    tick();
    chk("idle no fetch", int'(fetch_valid), 0);

    // Single thread sequential fetch
    do_start(0, 'h010); tick(); lit("t1 a", 0, 'h010);
    chk("t1 active", int'(thread_active), 1);
    tick(); lit("t1 b", 0, 'h011);
    tick(); lit("t1 c", 0, 'h012);

    // Four threads started on consecutive cycles, then free run with wrap
    apply_reset();
    do_start(0, 'h000); tick(); lit("t2 s0", 0, 'h000);
    do_start(1, 'h100); tick(); lit("t2 s1", 1, 'h100);
    do_start(2, 'h080); tick(); lit("t2 s2", 2, 'h080);
    do_start(3, 'h1F0); tick(); lit("t2 s3", 3, 'h1F0);
    tick(); lit("t2 r0", 0, 'h001);
    do_redirect(2, 'h1FF); tick(); lit("t2 r1", 1, 'h101);
    tick(); lit("t3 wrap a", 2, 'h1FF);
    tick(); lit("t2 r3", 3, 'h1F1);
    tick(); lit("t2 r0b", 0, 'h002);
    tick(); lit("t2 r1b", 1, 'h102);
    tick(); lit("t3 wrap b", 2, 'h000);

    // Redirect of the thread granted in the same cycle
    tick(); lit("t4 a", 3, 'h1F2);
    tick(); lit("t4 b", 0, 'h003);
    do_redirect(1, 'h0AA); tick(); lit("t4 redir", 1, 'h0AA);
    tick(); lit("t4 c", 2, 'h001);
    tick(); lit("t4 d", 3, 'h1F3);
    tick(); lit("t4 e", 0, 'h004);
    tick(); lit("t4 next", 1, 'h0AB);

    // Stall for three cycles with a redirect applied underneath
    stall = 1; do_redirect(3, 'h055); tick(); lit("t5 frz a", 1, 'h0AB);
    stall = 1; tick(); lit("t5 frz b", 1, 'h0AB);
    stall = 1; tick(); lit("t5 frz c", 1, 'h0AB);
    tick(); lit("t5 resume", 2, 'h002);
    tick(); lit("t5 tid3", 3, 'h055);
    tick(); lit("t5 tid0", 0, 'h005);

    // Halt of the only active thread; start+halt on the same thread
    apply_reset();
    do_start(0, 'h020); tick(); lit("t6 a", 0, 'h020);
    halt_valid = 1; halt_tid = 2'd0; tick();
    chk("t6 halt valid", int'(fetch_valid), 0);
    chk("t6 halt active", int'(thread_active), 0);
    do_start(1, 'h030); halt_valid = 1; halt_tid = 2'd1; tick();
    lit("t6 start+halt", 1, 'h030);
    chk("t6 sh active", int'(thread_active), 2);

    // Randomized traffic with occasional asynchronous reset
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) apply_reset();
      stall          = ($urandom % 5) == 0;
      start_valid    = ($urandom % 6) == 0;
      start_tid      = TW'($urandom % NT);
      start_addr     = ($urandom % 4 == 0) ? PW'(510 + ($urandom % 2)) : PW'($urandom);
      halt_valid     = ($urandom % 8) == 0;
      halt_tid       = TW'($urandom % NT);
      redirect_valid = ($urandom % 3) == 0;
      redirect_tid   = TW'($urandom % NT);
      redirect_addr  = ($urandom % 4 == 0) ? PW'(511) : PW'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/thread_pc_sched.md
# thread_pc_sched

Fine-grained multithreaded fetch scheduler that owns one 9-bit program counter per hardware thread and issues one instruction-memory fetch address per cycle, rotating round-robin over active threads. It sits ahead of the instruction memory in place of a single-thread PC register. It absorbs branch redirects, thread start and thread halt events from the execute stage, and honours a downstream fetch stall.

## Interface
- NUM_THREADS, 4, number of thread contexts; power of two, 2..8
- TID_W, 2, thread-id width; must equal log2(NUM_THREADS)
- PC_W, 9, program-counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  downstream cannot accept a fetch this cycle
- start_valid  in  1  load start_addr into thread start_tid's PC and activate it
- start_tid  in  TID_W  thread to start
- start_addr  in  PC_W  initial PC
- halt_valid  in  1  deactivate thread halt_tid
- halt_tid  in  TID_W  thread to halt
- redirect_valid  in  1  branch/jump taken for thread redirect_tid
- redirect_tid  in  TID_W  thread being redirected
- redirect_addr  in  PC_W  branch target
- fetch_valid  out  1  fetch_pc/fetch_tid hold a valid fetch request (registered)
- fetch_tid  out  TID_W  thread of the issued fetch (registered)
- fetch_pc  out  PC_W  address to fetch (registered)
- thread_active  out  NUM_THREADS  per-thread active flags (registered)

## Operation
- State: pc[t] for each thread, active[t], round-robin pointer last_tid.
- Eligible set = active[t] after this cycle's halt/start are applied. A thread halted this cycle is not eligible. A thread started this cycle is eligible.
- Non-stalled cycle: grant the first eligible thread searching last_tid+1, last_tid+2, … modulo NUM_THREADS. Then last_tid <= grant.
- The issued address is redirect_addr if redirect_valid and redirect_tid == grant; otherwise it is pc[grant].
- After issue, pc[grant] <= issued address + 1, wrapping modulo 2^PC_W (511 -> 0).
- Redirect to a thread that is not granted: pc[redirect_tid] <= redirect_addr. Applies to inactive threads too.
- Same-thread event priority: start > halt > redirect. Start on an active thread reloads its PC. Halt on an inactive thread is a no-op.
- Events on different threads in the same cycle all take effect.
- No eligible thread and no stall: fetch_valid <= 0. fetch_tid and fetch_pc hold their values. last_tid unchanged.
- Stall high:
  - no grant; fetch_valid, fetch_tid, fetch_pc and last_tid hold;
  - start, halt and redirect still update pc[] and active[].

## Timing
- One-cycle latency: events and grant decision in cycle N appear on the fetch_* and thread_active outputs after edge N+1.
- With all NUM_THREADS active and no stall, each thread issues exactly once every NUM_THREADS cycles.
- Reset (asynchronous, effective immediately):
  - pc[] = 0, active = 0;
  - last_tid = NUM_THREADS-1, so thread 0 is granted first;
  - fetch_valid = 0, fetch_tid = 0, fetch_pc = 0, thread_active = 0.
- Reset asserted mid-run discards all pending state. First fetch comes no earlier than one cycle after the first start_valid following reset release.

## Configuration
- SCHED_PERF_CNT_EN defined:
  - adds output issue_count (32 bits), reset to 0;
  - increments on every cycle that registers fetch_valid = 1 from a new grant;
  - wraps at 2^32.
- SCHED_PERF_CNT_EN undefined: issue_count port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, start tid0 at 0x010 -> next cycle fetch_valid=1, tid0, pc 0x010, then 0x011 and 0x012 on successive cycles; thread_active=4'b0001.
- Start tids 0–3 at 0x000/0x100/0x080/0x1F0 on consecutive cycles, then free run -> steady grant order 0,1,2,3,0… with each thread's PC incrementing by 1 per visit.
- Thread 2 at PC 0x1FF is granted -> issues 0x1FF; its next issue is 0x000.
- Redirect tid1 to 0x0AA in the cycle tid1 is granted -> fetch_pc=0x0AA; tid1's next issue is 0x0AB.
- Stall held 3 cycles while redirect tid3 -> 0x055 -> outputs frozen during the stall; after release rotation resumes from the held last_tid, and tid3 next issues 0x055.
- Halt tid0 while it would be granted, with only tid0 active -> tid0 not issued, fetch_valid=0 next cycle, thread_active=0; same-cycle start+halt on tid1 -> tid1 active.
